// File: rtl/z80_bus_monitor.sv
// Z80 bus-cycle monitor: classifies each mreq/iorq cycle, logs it to a FWFT FIFO, stretches cycles via /WAIT.
// Record lands 2 clocks after the strobe rises; a full FIFO drops new records (counted) unless popped that clock.

// Generic first-word-fall-through FIFO; read data visible the clock after the write.
// wr_rdy drops when full unless the head is popped in the same clock.
module z80_bus_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic [W-1:0]  last;
  logic          push, pop;

  assign rd_vld = (cnt != '0);
  assign pop    = rd_vld & rd_rdy;
  assign wr_rdy = (cnt != FULL_CNT) | pop;
  assign push   = wr_vld & wr_rdy;
  // Fields hold the most recently shown head once the FIFO drains.
  assign rd_dat = rd_vld ? mem[rptr] : last;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      last <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (pop && !push) cnt <= cnt - (AW+1)'(1);
      if (rd_vld) last <= mem[rptr];
    end
  end
endmodule

module z80_bus_monitor #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int LEN_W       = 4,
  parameter int WAIT_MEM    = 0,
  parameter int WAIT_IO     = 1,
  parameter int LOG_REFRESH = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              m1_n,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              rfsh_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wait_en,
  output logic              wait_n,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [2:0]        rec_type,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [DATA_W-1:0] rec_data,
  output logic [LEN_W-1:0]  rec_len,
  output logic [15:0]       drop_cnt,
  output logic [2:0]        err,
  input  logic              err_clr
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [2:0] T_OPFETCH = 3'd0;
  localparam logic [2:0] T_MEMRD   = 3'd1;
  localparam logic [2:0] T_MEMWR   = 3'd2;
  localparam logic [2:0] T_IORD    = 3'd3;
  localparam logic [2:0] T_IOWR    = 3'd4;
  localparam logic [2:0] T_INTACK  = 3'd5;
  localparam logic [2:0] T_REFRESH = 3'd6;
  localparam logic [2:0] T_UNKNOWN = 3'd7;

  localparam int REC_W = 3 + ADDR_W + DATA_W + LEN_W;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [7:0] WAIT_MEM_C = 8'(WAIT_MEM);
  localparam logic [7:0] WAIT_IO_C  = 8'(WAIT_IO);

  logic [1:0]        state;
  logic              prev_mreq_n, prev_iorq_n;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [LEN_W-1:0]  cur_len;
  logic              f_m1, f_rfsh, f_io, f_rd, f_wr;
  logic [7:0]        wcnt;

  logic              strobe, strobe_edge, start, xfer, len_sat;
  logic [2:0]        cls;
  logic              push, push_rdy;
  logic [7:0]        wait_load;
  logic [REC_W-1:0]  head;

  assign strobe = ~mreq_n | ~iorq_n;
  // Previous pins reset to "asserted" so a strobe already low at reset release is not an edge.
  assign strobe_edge = strobe & prev_mreq_n & prev_iorq_n;
  assign start   = strobe_edge & (state != ACTIVE);
  assign xfer    = ~rd_n | ~wr_n;
  assign len_sat = (state == ACTIVE) & strobe & (cur_len == LEN_MAX);

  always_comb begin
    cls = T_UNKNOWN;
    if (f_rfsh)             cls = T_REFRESH;
    else if (f_m1 && f_io)  cls = T_INTACK;
    else if (f_m1)          cls = T_OPFETCH;
    else if (f_io && f_rd)  cls = T_IORD;
    else if (f_io && f_wr)  cls = T_IOWR;
    else if (f_rd)          cls = T_MEMRD;
    else if (f_wr)          cls = T_MEMWR;
  end

  assign push = (state == DONE) & ((LOG_REFRESH != 0) | ~f_rfsh);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      prev_mreq_n <= 1'b0;
      prev_iorq_n <= 1'b0;
      cur_addr    <= '0;
      cur_data    <= '0;
      cur_len     <= '0;
      {f_m1, f_rfsh, f_io, f_rd, f_wr} <= '0;
    end else begin
      prev_mreq_n <= mreq_n;
      prev_iorq_n <= iorq_n;
      if (start) begin
        state    <= ACTIVE;
        cur_addr <= addr;
        cur_len  <= LEN_W'(1);
        if (xfer) cur_data <= data;
        {f_m1, f_rfsh, f_io, f_rd, f_wr} <= {~m1_n, ~rfsh_n, ~iorq_n, ~rd_n, ~wr_n};
      end else begin
        case (state)
          ACTIVE: begin
            if (strobe) begin
              if (!len_sat) cur_len <= cur_len + LEN_W'(1);
              if (xfer) cur_data <= data;
              f_m1   <= f_m1   | ~m1_n;
              f_rfsh <= f_rfsh | ~rfsh_n;
              f_io   <= f_io   | ~iorq_n;
              f_rd   <= f_rd   | ~rd_n;
              f_wr   <= f_wr   | ~wr_n;
            end else begin
              state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      drop_cnt <= '0;
    else if (push && !push_rdy && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      err <= '0;
    else if (err_clr)
      err <= '0;
    else
      err <= err | {len_sat, ~mreq_n & ~iorq_n, ~rd_n & ~wr_n};
  end

  assign wait_load = ~iorq_n ? WAIT_IO_C : WAIT_MEM_C;

  // wcnt holds the wait clocks still owed after the current low one.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wait_n <= 1'b1;
      wcnt   <= '0;
    end else if (!strobe || !rfsh_n || !wait_en) begin
      wait_n <= 1'b1;
      wcnt   <= '0;
    end else if (strobe_edge) begin
      if (wait_load != 8'd0) begin
        wait_n <= 1'b0;
        wcnt   <= wait_load - 8'd1;
      end else begin
        wait_n <= 1'b1;
        wcnt   <= '0;
      end
    end else if (!wait_n) begin
      if (wcnt != 8'd0) wcnt <= wcnt - 8'd1;
      else              wait_n <= 1'b1;
    end
  end

  z80_bus_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .wr_vld (push),
    .wr_dat ({cls, cur_addr, cur_data, cur_len}),
    .wr_rdy (push_rdy),
    .rd_vld (rec_valid),
    .rd_rdy (rec_ready),
    .rd_dat (head)
  );

  assign {rec_type, rec_addr, rec_data, rec_len} = head;
endmodule

// File: tb/tb_z80_bus_monitor.sv
// Directed bench for z80_bus_monitor: two instances (refresh discarded / logged) share one bus; scoreboard queue for dut0 records.
module tb_z80_bus_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  data = '0;
  logic        wait_en = 1'b1, rec_ready = 1'b0, rdy1 = 1'b0, err_clr = 1'b0;

  logic        wait_n0, rec_valid0, wait_n1, rec_valid1;
  logic [2:0]  rec_type0, rec_type1, err0, err1;
  logic [15:0] rec_addr0, rec_addr1, drop_cnt0, drop_cnt1;
  logic [7:0]  rec_data0, rec_data1;
  logic [3:0]  rec_len0, rec_len1;

  int vectors = 0;
  int miscompares = 0;
  logic [30:0] sb[$];

  always #5 clk = ~clk;

  z80_bus_monitor #(.DEPTH(4), .WAIT_MEM(0), .WAIT_IO(2), .LOG_REFRESH(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .addr(addr), .data(data),
    .wait_en(wait_en), .wait_n(wait_n0), .rec_valid(rec_valid0), .rec_ready(rec_ready),
    .rec_type(rec_type0), .rec_addr(rec_addr0), .rec_data(rec_data0), .rec_len(rec_len0),
    .drop_cnt(drop_cnt0), .err(err0), .err_clr(err_clr));

  z80_bus_monitor #(.LOG_REFRESH(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .addr(addr), .data(data),
    .wait_en(wait_en), .wait_n(wait_n1), .rec_valid(rec_valid1), .rec_ready(rdy1),
    .rec_type(rec_type1), .rec_addr(rec_addr1), .rec_data(rec_data1), .rec_len(rec_len1),
    .drop_cnt(drop_cnt1), .err(err1), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_bus(input logic m1, mreq, iorq, rd, wr, rfsh, input logic [15:0] a, input logic [7:0] d);
    m1_n = m1; mreq_n = mreq; iorq_n = iorq; rd_n = rd; wr_n = wr; rfsh_n = rfsh;
    addr = a; data = d;
  endtask

  task automatic bus_idle();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  function automatic logic [30:0] mk(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d, input logic [3:0] l);
    return {t, a, d, l};
  endfunction

  // Wait (bounded) for a record, compare it with the scoreboard head, then pop it.
  task automatic pop_check(input string tag);
    logic [30:0] exp;
    int n = 0;
    while (!rec_valid0 && n < 20) begin
      tick(1);
      n++;
    end
    chk({tag, " valid"}, {31'd0, rec_valid0}, 32'd1);
    exp = '1;
    if (sb.size() != 0) exp = sb.pop_front();
    chk({tag, " rec"}, {1'b0, rec_type0, rec_addr0, rec_data0, rec_len0}, {1'b0, exp});
    rec_ready = 1'b1;
    tick(1);
    rec_ready = 1'b0;
  endtask

  // MEMRD: strobe low for 2 clocks, then 2 idle clocks (record pushed on the last one).
  task automatic rd_cycle(input logic [15:0] a, input logic [7:0] d);
    set_bus(1, 0, 1, 0, 1, 1, a, d);
    tick(2);
    bus_idle();
    tick(2);
  endtask

  initial begin
    tick(3);
    chk("rst wait_n", {31'd0, wait_n0}, 32'd1);
    chk("rst rec_valid", {31'd0, rec_valid0}, 32'd0);
    chk("rst fields", {1'b0, rec_type0, rec_addr0, rec_data0, rec_len0}, 32'd0);
    chk("rst drop_cnt", {16'd0, drop_cnt0}, 32'd0);
    chk("rst err", {29'd0, err0}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Refresh: discarded by dut0, logged by dut1; never waited
    set_bus(1, 0, 1, 1, 1, 0, 16'h0001, 8'h00);
    tick(1);
    chk("refresh wait_n", {31'd0, wait_n0}, 32'd1);
    bus_idle();
    tick(4);
    chk("refresh no rec", {31'd0, rec_valid0}, 32'd0);
    chk("refresh drop", {16'd0, drop_cnt0}, 32'd0);
    chk("refresh log valid", {31'd0, rec_valid1}, 32'd1);
    chk("refresh log type/len", {25'd0, rec_type1, rec_len1}, {25'd0, 3'd6, 4'd1});
    chk("refresh log addr", {16'd0, rec_addr1}, 32'h0001);
    rdy1 = 1'b1;
    tick(1);
    chk("refresh log popped", {31'd0, rec_valid1}, 32'd0);

    // Opcode fetch; WAIT_MEM=0 never asserts wait
    set_bus(0, 0, 1, 0, 1, 1, 16'h0000, 8'h3E);
    tick(1);
    chk("opfetch wait_n", {31'd0, wait_n0}, 32'd1);
    tick(1);
    bus_idle();
    sb.push_back(mk(3'd0, 16'h0000, 8'h3E, 4'd2));
    pop_check("opfetch");

    // Memory write, wr_n low on clocks 2-3
    set_bus(1, 0, 1, 1, 1, 1, 16'hAA20, 8'hFF);
    tick(1);
    set_bus(1, 0, 1, 1, 0, 1, 16'hAA20, 8'h1D);
    tick(2);
    bus_idle();
    sb.push_back(mk(3'd2, 16'hAA20, 8'h1D, 4'd3));
    pop_check("memwr");

    // I/O read with 2 wait clocks, strobe held 4 clocks
    set_bus(1, 1, 0, 0, 1, 1, 16'h0010, 8'h55);
    chk("ioread wait pre", {31'd0, wait_n0}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("ioread wait seq", {31'd0, wait_n0}, (i < 2) ? 32'd0 : 32'd1);
    end
    bus_idle();
    sb.push_back(mk(3'd3, 16'h0010, 8'h55, 4'd4));
    pop_check("ioread");

    wait_en = 1'b0;
    set_bus(1, 1, 0, 0, 1, 1, 16'h0011, 8'h66);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("wait disabled", {31'd0, wait_n0}, 32'd1);
    end
    bus_idle();
    wait_en = 1'b1;
    sb.push_back(mk(3'd3, 16'h0011, 8'h66, 4'd3));
    pop_check("ioread nowait");

    // Strobe released while waiting: wait_n released on the next clock
    set_bus(1, 1, 0, 1, 0, 1, 16'h0012, 8'h77);
    tick(1);
    chk("iowr wait low", {31'd0, wait_n0}, 32'd0);
    bus_idle();
    tick(1);
    chk("iowr wait released", {31'd0, wait_n0}, 32'd1);
    sb.push_back(mk(3'd4, 16'h0012, 8'h77, 4'd1));
    pop_check("iowr");

    // wait_en falling mid-count
    set_bus(1, 1, 0, 0, 1, 1, 16'h0013, 8'h88);
    tick(1);
    chk("wait_en drop low", {31'd0, wait_n0}, 32'd0);
    wait_en = 1'b0;
    tick(1);
    chk("wait_en drop release", {31'd0, wait_n0}, 32'd1);
    bus_idle();
    wait_en = 1'b1;
    sb.push_back(mk(3'd3, 16'h0013, 8'h88, 4'd2));
    pop_check("wait_en drop");

    // Overflow: 6 MEMRD with no pops, 4 kept
    for (int i = 0; i < 6; i++) begin
      rd_cycle(16'h0100 + 16'(i), 8'(i + 1));
      if (i < 4) sb.push_back(mk(3'd1, 16'h0100 + 16'(i), 8'(i + 1), 4'd2));
    end
    tick(1);
    chk("overflow drop_cnt", {16'd0, drop_cnt0}, 32'd2);
    for (int i = 0; i < 4; i++) pop_check("overflow");
    chk("overflow empty", {31'd0, rec_valid0}, 32'd0);
    chk("empty holds last", {16'd0, rec_addr0}, 32'h0103);

    // Full FIFO with a pop on the 5th push clock: push accepted
    for (int i = 0; i < 4; i++) begin
      rd_cycle(16'h0200 + 16'(i), 8'(i + 16));
      sb.push_back(mk(3'd1, 16'h0200 + 16'(i), 8'(i + 16), 4'd2));
    end
    set_bus(1, 0, 1, 0, 1, 1, 16'h0204, 8'h20);
    tick(2);
    bus_idle();
    tick(1);
    begin
      logic [30:0] exp0;
      exp0 = sb.pop_front();
      chk("fullpop head", {1'b0, rec_type0, rec_addr0, rec_data0, rec_len0}, {1'b0, exp0});
    end
    rec_ready = 1'b1;
    tick(1);
    rec_ready = 1'b0;
    sb.push_back(mk(3'd1, 16'h0204, 8'h20, 4'd2));
    chk("fullpop drop_cnt", {16'd0, drop_cnt0}, 32'd2);
    for (int i = 0; i < 4; i++) pop_check("fullpop");
    chk("fullpop empty", {31'd0, rec_valid0}, 32'd0);

    // Violations
    set_bus(1, 1, 1, 0, 0, 1, 16'h0030, 8'h00);
    tick(1);
    bus_idle();
    chk("err rd&wr", {29'd0, err0}, 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err clr", {29'd0, err0}, 32'd0);
    set_bus(1, 1, 1, 0, 0, 1, 16'h0030, 8'h00);
    err_clr = 1'b1;
    tick(1);
    bus_idle();
    err_clr = 1'b0;
    chk("err clr priority", {29'd0, err0}, 32'd0);
    set_bus(1, 0, 0, 0, 1, 1, 16'h0040, 8'h99);
    tick(1);
    bus_idle();
    tick(1);
    chk("err mreq&iorq", {29'd0, err0}, 32'd2);
    sb.push_back(mk(3'd3, 16'h0040, 8'h99, 4'd1));
    pop_check("mreq&iorq");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;

    // Length saturation
    set_bus(1, 0, 1, 0, 1, 1, 16'h0060, 8'h11);
    tick(17);
    bus_idle();
    sb.push_back(mk(3'd1, 16'h0060, 8'h11, 4'd15));
    pop_check("len sat");
    chk("err len sat", {29'd0, err0}, 32'd4);

    // Reset mid-ACTIVE while waiting, strobe held through release
    set_bus(1, 1, 0, 0, 1, 1, 16'h0050, 8'hAB);
    tick(1);
    chk("rst mid wait low", {31'd0, wait_n0}, 32'd0);
    rst = 1'b1;
    tick(1);
    chk("rst mid wait_n", {31'd0, wait_n0}, 32'd1);
    rst = 1'b0;
    tick(3);
    chk("rst mid no rec", {31'd0, rec_valid0}, 32'd0);
    chk("rst mid wait held", {31'd0, wait_n0}, 32'd1);
    bus_idle();
    tick(4);
    chk("rst mid no rec after", {31'd0, rec_valid0}, 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
